// File: rtl/div_n_bit_if.sv
// Start/done handshake bundle between the register file and the iterative divider.
// The master side drives the request and the operands; the slave side returns status and results.
interface div_n_bit_if #(
  parameter int word_size = 32
);
  logic                 start;
  logic [word_size-1:0] R2;
  logic [word_size-1:0] R3;
  logic                 busy;
  logic                 done;
  logic [word_size-1:0] QUO_out;
  logic [word_size-1:0] REM_out;
  logic                 div_zero;

  modport master (
    output start, R2, R3,
    input  busy, done, QUO_out, REM_out, div_zero
  );

  modport slave (
    input  start, R2, R3,
    output busy, done, QUO_out, REM_out, div_zero
  );
endinterface

// File: rtl/div_n_bit.sv
// Multi-cycle unsigned restoring divider: QUO_out = R2 / R3, REM_out = R2 % R3.
// Retires one quotient bit per clock; divide-by-zero short-circuits straight to DONE.
module div_n_bit #(
  parameter int word_size = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  div_n_bit_if.slave  bus
);

  localparam int cnt_w = (word_size > 2) ? $clog2(word_size) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [word_size:0]   p_reg;
  logic [word_size:0]   p_next;
  logic [word_size:0]   shifted;
  logic [word_size:0]   trial;
  logic [word_size-1:0] q_reg;
  logic [word_size-1:0] q_next;
  logic [word_size-1:0] d_reg;
  logic [cnt_w-1:0]     cnt;
  logic                 last_iter;
  logic [word_size-1:0] quo_reg;
  logic [word_size-1:0] rem_reg;
  logic                 div_zero_reg;

  assign last_iter = (cnt == cnt_w'(word_size - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus one restoring step: a negative trial difference keeps the shifted remainder.
  always_comb begin
    state_next = state;
    shifted    = {p_reg[word_size-1:0], q_reg[word_size-1]};
    trial      = shifted - {1'b0, d_reg};
    p_next     = shifted;
    q_next     = {q_reg[word_size-2:0], 1'b0};
    if (!trial[word_size]) begin
      p_next = trial;
      q_next = {q_reg[word_size-2:0], 1'b1};
    end
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.R3 == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are written only on entry to DONE, so they hold across the following operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_reg        <= '0;
      q_reg        <= '0;
      d_reg        <= '0;
      cnt          <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            d_reg <= bus.R3;
            q_reg <= bus.R2;
            p_reg <= '0;
            cnt   <= '0;
            if (bus.R3 == '0) begin
              quo_reg      <= '1;
              rem_reg      <= bus.R2;
              div_zero_reg <= 1'b1;
            end
          end
        end
        CALC: begin
          p_reg <= p_next;
          q_reg <= q_next;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            quo_reg      <= q_next;
            rem_reg      <= p_next[word_size-1:0];
            div_zero_reg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = (state == CALC);
  assign bus.done     = (state == DONE);
  assign bus.QUO_out  = quo_reg;
  assign bus.REM_out  = rem_reg;
  assign bus.div_zero = div_zero_reg;

endmodule

// File: tb/tb_div_n_bit.sv
// Directed and small random-vector bench for the 32-bit div_n_bit.
// Expected quotients/remainders come from hand-computed constants or the bench's own / and %.
module tb_div_n_bit;

  localparam int ws = 32;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  div_n_bit_if #(.word_size(ws)) bus ();

  div_n_bit #(.word_size(ws)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [ws-1:0] got, input logic [ws-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Presents one request for a single cycle; returns #1 after the accepting edge E0.
  task automatic applyStimulus(input logic [ws-1:0] a, input logic [ws-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.R2    = a;
    bus.R3    = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busy_cycles);
    lat         = 0;
    busy_cycles = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [ws-1:0] a, input logic [ws-1:0] b);
    int lat;
    int busy_cycles;
    logic [ws-1:0] exp_q;
    logic [ws-1:0] exp_r;
    exp_q = (b == 0) ? '1 : a / b;
    exp_r = (b == 0) ? a : a % b;
    applyStimulus(a, b);
    waitDone(lat, busy_cycles);
    checkOutput({tag, "_done"}, ws'(bus.done), 1);
    checkOutput({tag, "_lat"}, ws'(lat), (b == 0) ? 0 : ws);
    checkOutput({tag, "_busycyc"}, ws'(busy_cycles), (b == 0) ? 0 : ws);
    checkOutput({tag, "_busy_at_done"}, ws'(bus.busy), 0);
    checkOutput({tag, "_quo"}, bus.QUO_out, exp_q);
    checkOutput({tag, "_rem"}, bus.REM_out, exp_r);
    checkOutput({tag, "_dz"}, ws'(bus.div_zero), (b == 0) ? 1 : 0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_pulse"}, ws'(bus.done), 0);
  endtask

  initial begin
    int lat;
    int busy_cycles;
    logic [ws-1:0] a;
    logic [ws-1:0] b;
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.R2    = '0;
    bus.R3    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", ws'(bus.busy), 0);
    checkOutput("rst_done", ws'(bus.done), 0);
    checkOutput("rst_quo", bus.QUO_out, 0);
    checkOutput("rst_rem", bus.REM_out, 0);
    checkOutput("rst_dz", ws'(bus.div_zero), 0);
    @(negedge clk);
    reset_n = 1'b1;

    runOp("d100_7", 100, 7);
    checkOutput("d100_7_q_const", bus.QUO_out, 14);
    checkOutput("d100_7_r_const", bus.REM_out, 2);
    runOp("dmax_1", 32'hFFFF_FFFF, 1);
    runOp("d5_9", 5, 9);
    checkOutput("d5_9_q_const", bus.QUO_out, 0);
    runOp("d1234_0", 1234, 0);
    checkOutput("d1234_0_r_const", bus.REM_out, 1234);

    // Request and operand changes while busy must not disturb the running division.
    applyStimulus(200, 3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.R2    = 7;
    bus.R3    = 7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.R2    = 1;
    bus.R3    = 1;
    waitDone(lat, busy_cycles);
    checkOutput("ign_done", ws'(bus.done), 1);
    checkOutput("ign_quo", bus.QUO_out, 66);
    checkOutput("ign_rem", bus.REM_out, 2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ign_idle_busy", ws'(bus.busy), 0);
    checkOutput("ign_hold_quo", bus.QUO_out, 66);

    // Asynchronous reset in the middle of CALC clears outputs at once and suppresses done.
    applyStimulus(100, 7);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_quo", bus.QUO_out, 0);
    checkOutput("mid_rst_rem", bus.REM_out, 0);
    checkOutput("mid_rst_busy", ws'(bus.busy), 0);
    checkOutput("mid_rst_done", ws'(bus.done), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      checkOutput("mid_rst_nodone", ws'(bus.done), 0);
    end
    runOp("d50_5", 50, 5);

    for (int i = 0; i < 120; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      runOp("rnd", a, b);
      if (b != 0) begin
        checkOutput("rnd_rem_lt", ws'(bus.REM_out < b), 1);
        checkOutput("rnd_recon", bus.QUO_out * b + bus.REM_out, a);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
